// File: rtl/bsg_mul_iterative_mac_pkg.sv
// Shared types and helpers for the iterative multiply-accumulate unit.
package bsg_mul_iterative_mac_pkg;

    typedef enum logic [1:0] {
        eIDLE = 2'd0,
        eCAL  = 2'd1,
        eFIN  = 2'd2,
        eDONE = 2'd3
    } bsg_mul_iterative_mac_state_e;

    // Number of eCAL cycles needed to retire all multiplier digits.
    function automatic int unsigned bsg_mul_iterative_mac_iter_count(
        input int unsigned width,
        input int unsigned step
    );
        return width / step;
    endfunction

endpackage

// File: rtl/bsg_mul_iterative_mac_if.sv
// Request/response bundle for the iterative MAC unit; signal suffixes are from the unit's view.
interface bsg_mul_iterative_mac_if #(
    parameter int unsigned width_p      = 32,
    parameter int unsigned full_sized_p = 1,
    parameter int unsigned tag_width_p  = 1
);
    localparam int unsigned output_size_lp = (full_sized_p != 0) ? 2 * width_p : width_p;

    logic                      v_i;
    logic                      ready_o;
    logic [width_p-1:0]        opA_i;
    logic                      opA_is_signed_i;
    logic [width_p-1:0]        opB_i;
    logic                      opB_is_signed_i;
    logic                      acc_en_i;
    logic [output_size_lp-1:0] acc_i;
    logic [tag_width_p-1:0]    tag_i;
    logic [output_size_lp-1:0] result_o;
    logic [tag_width_p-1:0]    tag_o;
    logic                      v_o;
    logic                      yumi_i;

    // Issue side: drives operations and consumes results.
    modport master (
        output v_i, opA_i, opA_is_signed_i, opB_i, opB_is_signed_i,
        output acc_en_i, acc_i, tag_i, yumi_i,
        input  ready_o, result_o, tag_o, v_o
    );

    // Functional unit side.
    modport slave (
        input  v_i, opA_i, opA_is_signed_i, opB_i, opB_is_signed_i,
        input  acc_en_i, acc_i, tag_i, yumi_i,
        output ready_o, result_o, tag_o, v_o
    );

endinterface

// File: rtl/bsg_mul_iterative_mac_step.sv
// Combinational digit step: adds |A| * digit, aligned to digit position idx_i, into the product.
module bsg_mul_iterative_mac_step #(
    parameter int unsigned width_p     = 32,
    parameter int unsigned iter_step_p = 8,
    parameter int unsigned idx_width_p = 2
) (
    input  logic [width_p-1:0]     a_mag_i,
    input  logic [iter_step_p-1:0] b_digit_i,
    input  logic [2*width_p-1:0]   prod_i,
    input  logic [idx_width_p-1:0] idx_i,
    output logic [2*width_p-1:0]   prod_o
);

    logic [2*width_p-1:0] digit_ext;
    logic [2*width_p-1:0] partial;
    logic [31:0]          shamt;

    // Partial product fits in 2*width_p bits since digit < 2^iter_step_p <= 2^width_p.
    always_comb begin
        digit_ext                   = '0;
        digit_ext[iter_step_p-1:0]  = b_digit_i;
        partial                     = {{width_p{1'b0}}, a_mag_i} * digit_ext;
        shamt                       = 32'(idx_i) * iter_step_p;
        prod_o                      = prod_i + (partial << shamt);
    end

endmodule

// File: rtl/bsg_mul_iterative_mac.sv
// Iterative multiply-accumulate: result = A*B + acc, iter_step_p multiplier bits per cycle.
// Optional macro BSG_MUL_ITERATIVE_MAC_EARLY_OUT_EN ends eCAL once the remaining multiplier is zero.
module bsg_mul_iterative_mac
    import bsg_mul_iterative_mac_pkg::*;
#(
    parameter int unsigned width_p      = 32,
    parameter int unsigned iter_step_p  = 8,
    parameter int unsigned full_sized_p = 1,
    parameter int unsigned tag_width_p  = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    bsg_mul_iterative_mac_if.slave mac_io
);

    localparam int unsigned output_size_lp = (full_sized_p != 0) ? 2 * width_p : width_p;
    localparam int unsigned iter_count_lp  =
        bsg_mul_iterative_mac_iter_count(width_p, iter_step_p);
    localparam int unsigned cnt_width_lp   = (iter_count_lp > 1) ? $clog2(iter_count_lp) : 1;
    localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(iter_count_lp - 1);

    bsg_mul_iterative_mac_state_e state_q, state_d;

    logic [width_p-1:0]        a_mag_q, a_mag_d;
    logic [width_p-1:0]        b_rem_q, b_rem_d;
    logic                      neg_q, neg_d;
    logic [output_size_lp-1:0] acc_q, acc_d;
    logic [tag_width_p-1:0]    tag_q, tag_d;
    logic [2*width_p-1:0]      prod_q, prod_d;
    logic [cnt_width_lp-1:0]   cnt_q, cnt_d;
    logic [output_size_lp-1:0] result_q, result_d;

    logic                      a_neg, b_neg;
    logic [2*width_p-1:0]      prod_step;
    logic [2*width_p-1:0]      prod_signed;

    bsg_mul_iterative_mac_step #(
        .width_p     (width_p),
        .iter_step_p (iter_step_p),
        .idx_width_p (cnt_width_lp)
    ) u_step (
        .a_mag_i   (a_mag_q),
        .b_digit_i (b_rem_q[iter_step_p-1:0]),
        .prod_i    (prod_q),
        .idx_i     (cnt_q),
        .prod_o    (prod_step)
    );

    // Next-state and datapath update for the accept/iterate/finish/hold sequence.
    always_comb begin
        state_d     = state_q;
        a_mag_d     = a_mag_q;
        b_rem_d     = b_rem_q;
        neg_d       = neg_q;
        acc_d       = acc_q;
        tag_d       = tag_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        a_neg       = mac_io.opA_i[width_p-1] & mac_io.opA_is_signed_i;
        b_neg       = mac_io.opB_i[width_p-1] & mac_io.opB_is_signed_i;
        prod_signed = neg_q ? -prod_q : prod_q;

        unique case (state_q)
            eIDLE: begin
                if (mac_io.v_i) begin
                    // Unary minus maps the most-negative value onto its own magnitude.
                    a_mag_d = a_neg ? -mac_io.opA_i : mac_io.opA_i;
                    b_rem_d = b_neg ? -mac_io.opB_i : mac_io.opB_i;
                    neg_d   = a_neg ^ b_neg;
                    acc_d   = mac_io.acc_en_i ? mac_io.acc_i : '0;
                    tag_d   = mac_io.tag_i;
                    prod_d  = '0;
                    cnt_d   = '0;
                    state_d = eCAL;
                end
            end
            eCAL: begin
                prod_d  = prod_step;
                b_rem_d = b_rem_q >> iter_step_p;
                cnt_d   = cnt_q + cnt_width_lp'(1);
                if (cnt_q == last_cnt_lp) begin
                    state_d = eFIN;
                end
`ifdef BSG_MUL_ITERATIVE_MAC_EARLY_OUT_EN
                if (b_rem_d == '0) begin
                    state_d = eFIN;
                end
`endif
            end
            eFIN: begin
                result_d = prod_signed[output_size_lp-1:0] + acc_q;
                state_d  = eDONE;
            end
            eDONE: begin
                if (mac_io.yumi_i) begin
                    state_d = eIDLE;
                end
            end
            default: state_d = eIDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= eIDLE;
            a_mag_q  <= '0;
            b_rem_q  <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            tag_q    <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_mag_q  <= a_mag_d;
            b_rem_q  <= b_rem_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            tag_q    <= tag_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign mac_io.ready_o  = (state_q == eIDLE);
    assign mac_io.v_o      = (state_q == eDONE);
    assign mac_io.result_o = result_q;
    assign mac_io.tag_o    = tag_q;

endmodule

// File: tb/tb_bsg_mul_iterative_mac.sv
// Directed bench for bsg_mul_iterative_mac: full-width and half-width instances side by side.
module tb_bsg_mul_iterative_mac;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    bsg_mul_iterative_mac_if #(.width_p(32), .full_sized_p(1), .tag_width_p(4)) f_if ();
    bsg_mul_iterative_mac_if #(.width_p(32), .full_sized_p(0), .tag_width_p(4)) h_if ();

    bsg_mul_iterative_mac #(
        .width_p      (32),
        .iter_step_p  (8),
        .full_sized_p (1),
        .tag_width_p  (4)
    ) u_full (
        .clk_i   (clk),
        .reset_i (rst),
        .mac_io  (f_if.slave)
    );

    bsg_mul_iterative_mac #(
        .width_p      (32),
        .iter_step_p  (8),
        .full_sized_p (0),
        .tag_width_p  (4)
    ) u_half (
        .clk_i   (clk),
        .reset_i (rst),
        .mac_io  (h_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected accept-to-v_o cycles for a given multiplier magnitude.
    function automatic int exp_lat(input logic [31:0] bmag);
`ifdef BSG_MUL_ITERATIVE_MAC_EARLY_OUT_EN
        int d = 1;
        for (int i = 0; i < 4; i++) begin
            if (bmag[8*i +: 8] != 8'h00) d = i + 1;
        end
        return d + 2;
`else
        return 6;
`endif
    endfunction

    // Called #1 after a posedge; presents the op for one cycle, returns cycles until v_o.
    task automatic issue_full(input logic [31:0] a, input logic as, input logic [31:0] b,
                              input logic bs, input logic ae, input logic [63:0] acc,
                              input logic [3:0] tag, output int lat);
        f_if.v_i = 1'b1;  f_if.opA_i = a;  f_if.opA_is_signed_i = as;
        f_if.opB_i = b;   f_if.opB_is_signed_i = bs;
        f_if.acc_en_i = ae;  f_if.acc_i = acc;  f_if.tag_i = tag;
        @(posedge clk); #1;
        f_if.v_i = 1'b0;
        lat = 1;
        while (f_if.v_o !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume_full();
        f_if.yumi_i = 1'b1;
        @(posedge clk); #1;
        f_if.yumi_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks += 8;
        if (f_if.ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", f_if.ready_o); end
        if (f_if.v_o !== 1'b0) begin failures++; $display("FAIL reset_v got=%b want=0", f_if.v_o); end
        if (f_if.result_o !== 64'h0) begin failures++; $display("FAIL reset_result got=%h want=0", f_if.result_o); end
        if (f_if.tag_o !== 4'h0) begin failures++; $display("FAIL reset_tag got=%h want=0", f_if.tag_o); end
        if (h_if.ready_o !== 1'b1) begin failures++; $display("FAIL reset_h_ready got=%b want=1", h_if.ready_o); end
        if (h_if.v_o !== 1'b0) begin failures++; $display("FAIL reset_h_v got=%b want=0", h_if.v_o); end
        if (h_if.result_o !== 32'h0) begin failures++; $display("FAIL reset_h_result got=%h want=0", h_if.result_o); end
        if (h_if.tag_o !== 4'h0) begin failures++; $display("FAIL reset_h_tag got=%h want=0", h_if.tag_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        int lat;
        issue_full(32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'h0, 4'h3, lat);
        checks += 5;
        if (lat != 6) begin failures++; $display("FAIL unsigned_latency got=%0d want=6", lat); end
        if (f_if.result_o !== 64'hFFFF_FFFE_0000_0001) begin
            failures++; $display("FAIL unsigned_result got=%h want=fffffffe00000001", f_if.result_o);
        end
        if (f_if.tag_o !== 4'h3) begin failures++; $display("FAIL unsigned_tag got=%h want=3", f_if.tag_o); end
        if (f_if.ready_o !== 1'b0) begin failures++; $display("FAIL unsigned_ready_done got=%b want=0", f_if.ready_o); end
        consume_full();
        if (f_if.ready_o !== 1'b1 || f_if.v_o !== 1'b0) begin
            failures++; $display("FAIL unsigned_after_yumi got=%b%b want=10", f_if.ready_o, f_if.v_o);
        end
    endtask

    task automatic test_signed_acc();
        int lat;
        issue_full(32'hFFFF_FFFD, 1'b1, 32'd7, 1'b1, 1'b1, 64'd100, 4'hA, lat);
        checks += 3;
        if (lat != exp_lat(32'd7)) begin
            failures++; $display("FAIL signed_acc_latency got=%0d want=%0d", lat, exp_lat(32'd7));
        end
        if (f_if.result_o !== 64'h0000_0000_0000_004F) begin
            failures++; $display("FAIL signed_acc_result got=%h want=4f", f_if.result_o);
        end
        if (f_if.tag_o !== 4'hA) begin failures++; $display("FAIL signed_acc_tag got=%h want=a", f_if.tag_o); end
        consume_full();
    endtask

    task automatic test_most_negative();
        int lat;
        issue_full(32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 64'h0, 4'h5, lat);
        checks += 2;
        if (lat != 6) begin failures++; $display("FAIL most_neg_latency got=%0d want=6", lat); end
        if (f_if.result_o !== 64'h4000_0000_0000_0000) begin
            failures++; $display("FAIL most_neg_result got=%h want=4000000000000000", f_if.result_o);
        end
        consume_full();
    endtask

    task automatic test_mixed_sign();
        int lat;
        // Signed -1 times unsigned 2.
        issue_full(32'hFFFF_FFFF, 1'b1, 32'd2, 1'b0, 1'b0, 64'h0, 4'h1, lat);
        checks += 2;
        if (lat != exp_lat(32'd2)) begin
            failures++; $display("FAIL mixed_a_latency got=%0d want=%0d", lat, exp_lat(32'd2));
        end
        if (f_if.result_o !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            failures++; $display("FAIL mixed_a_result got=%h want=fffffffffffffffe", f_if.result_o);
        end
        consume_full();
        // Unsigned 5 times signed -2.
        issue_full(32'd5, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 64'h0, 4'h2, lat);
        checks += 1;
        if (f_if.result_o !== 64'hFFFF_FFFF_FFFF_FFF6) begin
            failures++; $display("FAIL mixed_b_result got=%h want=fffffffffffffff6", f_if.result_o);
        end
        consume_full();
    endtask

    task automatic test_acc_modes();
        int lat;
        // acc_i must be ignored when acc_en_i is low.
        issue_full(32'd5, 1'b0, 32'd5, 1'b0, 1'b0, 64'h1234, 4'h4, lat);
        checks += 1;
        if (f_if.result_o !== 64'd25) begin
            failures++; $display("FAIL acc_disabled got=%h want=19", f_if.result_o);
        end
        consume_full();
        // Accumulate wraps modulo 2^64.
        issue_full(32'd1, 1'b0, 32'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'h6, lat);
        checks += 1;
        if (f_if.result_o !== 64'h0) begin
            failures++; $display("FAIL acc_wrap got=%h want=0", f_if.result_o);
        end
        consume_full();
    endtask

    task automatic test_half_backpressure();
        int lat;
        h_if.v_i = 1'b1;  h_if.opA_i = 32'h0001_0000;  h_if.opA_is_signed_i = 1'b0;
        h_if.opB_i = 32'h0001_0000;  h_if.opB_is_signed_i = 1'b0;
        h_if.acc_en_i = 1'b1;  h_if.acc_i = 32'd5;  h_if.tag_i = 4'hC;
        @(posedge clk); #1;
        h_if.v_i = 1'b0;
        lat = 1;
        while (h_if.v_o !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks += 3;
        if (lat != exp_lat(32'h0001_0000)) begin
            failures++; $display("FAIL half_latency got=%0d want=%0d", lat, exp_lat(32'h0001_0000));
        end
        if (h_if.result_o !== 32'h0000_0005) begin
            failures++; $display("FAIL half_result got=%h want=00000005", h_if.result_o);
        end
        if (h_if.tag_o !== 4'hC) begin failures++; $display("FAIL half_tag got=%h want=c", h_if.tag_o); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (h_if.v_o !== 1'b1 || h_if.ready_o !== 1'b0 || h_if.result_o !== 32'h5
                || h_if.tag_o !== 4'hC) begin
                failures++;
                $display("FAIL half_hold cyc=%0d got v=%b rdy=%b res=%h tag=%h want v=1 rdy=0 res=5 tag=c",
                         i, h_if.v_o, h_if.ready_o, h_if.result_o, h_if.tag_o);
            end
        end
        h_if.yumi_i = 1'b1;
        @(posedge clk); #1;
        h_if.yumi_i = 1'b0;
        checks++;
        if (h_if.ready_o !== 1'b1) begin failures++; $display("FAIL half_release got=%b want=1", h_if.ready_o); end
    endtask

    task automatic test_mid_reset();
        int lat;
        f_if.v_i = 1'b1;  f_if.opA_i = 32'h1234_5678;  f_if.opA_is_signed_i = 1'b0;
        f_if.opB_i = 32'h8765_4321;  f_if.opB_is_signed_i = 1'b0;
        f_if.acc_en_i = 1'b0;  f_if.tag_i = 4'h9;
        @(posedge clk); #1;
        f_if.v_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (f_if.ready_o !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b want=0", f_if.ready_o); end
        rst = 1'b1;
        #1;
        checks += 3;
        if (f_if.v_o !== 1'b0) begin failures++; $display("FAIL midreset_v got=%b want=0", f_if.v_o); end
        if (f_if.ready_o !== 1'b1) begin failures++; $display("FAIL midreset_ready got=%b want=1", f_if.ready_o); end
        if (f_if.tag_o !== 4'h0) begin failures++; $display("FAIL midreset_tag got=%h want=0", f_if.tag_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        issue_full(32'd6, 1'b0, 32'd7, 1'b0, 1'b0, 64'h0, 4'h7, lat);
        checks += 2;
        if (lat != exp_lat(32'd7)) begin
            failures++; $display("FAIL midreset_next_latency got=%0d want=%0d", lat, exp_lat(32'd7));
        end
        if (f_if.result_o !== 64'd42) begin
            failures++; $display("FAIL midreset_next_result got=%h want=2a", f_if.result_o);
        end
        consume_full();
    endtask

    task automatic test_early_out();
        int lat;
        issue_full(32'h1234_5678, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 64'h0, 4'hE, lat);
        checks += 2;
`ifdef BSG_MUL_ITERATIVE_MAC_EARLY_OUT_EN
        if (lat != 3) begin failures++; $display("FAIL early_latency got=%0d want=3", lat); end
`else
        if (lat != 6) begin failures++; $display("FAIL early_latency got=%0d want=6", lat); end
`endif
        if (f_if.result_o !== 64'h0000_0000_369D_0368) begin
            failures++; $display("FAIL early_result got=%h want=369d0368", f_if.result_o);
        end
        consume_full();
        issue_full(32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 1'b1, 64'd9, 4'hF, lat);
        checks += 2;
        if (lat != exp_lat(32'h0)) begin
            failures++; $display("FAIL zero_b_latency got=%0d want=%0d", lat, exp_lat(32'h0));
        end
        if (f_if.result_o !== 64'd9) begin failures++; $display("FAIL zero_b_result got=%h want=9", f_if.result_o); end
        consume_full();
    endtask

    task automatic test_ignored_inputs();
        int lat;
        // yumi while idle is ignored.
        f_if.yumi_i = 1'b1;
        @(posedge clk); #1;
        f_if.yumi_i = 1'b0;
        checks++;
        if (f_if.ready_o !== 1'b1 || f_if.v_o !== 1'b0) begin
            failures++; $display("FAIL idle_yumi got=%b%b want=10", f_if.ready_o, f_if.v_o);
        end
        // A second request while busy is ignored.
        f_if.v_i = 1'b1;  f_if.opA_i = 32'd2;  f_if.opA_is_signed_i = 1'b0;
        f_if.opB_i = 32'd3;  f_if.opB_is_signed_i = 1'b0;  f_if.acc_en_i = 1'b0;  f_if.tag_i = 4'h2;
        @(posedge clk); #1;
        f_if.opA_i = 32'd9;  f_if.opB_i = 32'd9;  f_if.tag_i = 4'hB;
        lat = 1;
        while (f_if.v_o !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        f_if.v_i = 1'b0;
        checks += 2;
        if (f_if.result_o !== 64'd6) begin failures++; $display("FAIL busy_vi_result got=%h want=6", f_if.result_o); end
        if (f_if.tag_o !== 4'h2) begin failures++; $display("FAIL busy_vi_tag got=%h want=2", f_if.tag_o); end
        consume_full();
    endtask

    task automatic test_back_to_back();
        int lat;
        issue_full(32'd100, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 64'h0, 4'h8, lat);
        checks += 2;
        if (lat != 6) begin failures++; $display("FAIL b2b_first_latency got=%0d want=6", lat); end
        if (f_if.result_o !== 64'h0000_0000_6400_0000) begin
            failures++; $display("FAIL b2b_first_result got=%h want=64000000", f_if.result_o);
        end
        consume_full();
        // Next accept right after yumi: period iter_count+3 = 7 cycles.
        checks++;
        if (f_if.ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b want=1", f_if.ready_o); end
        issue_full(32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'd10, 4'hD, lat);
        checks += 2;
        if (f_if.result_o !== 64'd11) begin failures++; $display("FAIL b2b_second_result got=%h want=b", f_if.result_o); end
        if (f_if.tag_o !== 4'hD) begin failures++; $display("FAIL b2b_second_tag got=%h want=d", f_if.tag_o); end
        consume_full();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        f_if.v_i = 1'b0;  f_if.opA_i = '0;  f_if.opA_is_signed_i = 1'b0;  f_if.opB_i = '0;
        f_if.opB_is_signed_i = 1'b0;  f_if.acc_en_i = 1'b0;  f_if.acc_i = '0;  f_if.tag_i = '0;
        f_if.yumi_i = 1'b0;
        h_if.v_i = 1'b0;  h_if.opA_i = '0;  h_if.opA_is_signed_i = 1'b0;  h_if.opB_i = '0;
        h_if.opB_is_signed_i = 1'b0;  h_if.acc_en_i = 1'b0;  h_if.acc_i = '0;  h_if.tag_i = '0;
        h_if.yumi_i = 1'b0;
        @(posedge clk); #1;

        test_reset();
        test_unsigned();
        test_signed_acc();
        test_most_negative();
        test_mixed_sign();
        test_acc_modes();
        test_half_backpressure();
        test_mid_reset();
        test_early_out();
        test_ignored_inputs();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
